// File: rtl/cart_capture_ctrl_if.sv
// Capture-record, configuration and readout signals of the cartridge capture
// controller. The master side drives stimulus/config; the slave side is the controller.
interface cart_capture_ctrl_if #(
  parameter int DEPTH_LOG2 = 6,
  parameter int CNT_W      = 16
);
  logic [31:0]         cap_addr_i;
  logic [31:0]         cap_data_i;
  logic                cap_valid_i;
  logic                arm_i;
  logic                abort_i;
  logic [31:0]         trig_addr_i;
  logic [31:0]         trig_mask_i;
  logic [CNT_W-1:0]    post_count_i;
  logic [31:0]         rd_addr_o;
  logic [31:0]         rd_data_o;
  logic                rd_valid_o;
  logic                rd_ready_i;
  logic [1:0]          state_o;
  logic [DEPTH_LOG2:0] level_o;
  logic                overflow_o;
  logic                done_o;

  modport master (
    output cap_addr_i, cap_data_i, cap_valid_i, arm_i, abort_i,
           trig_addr_i, trig_mask_i, post_count_i, rd_ready_i,
    input  rd_addr_o, rd_data_o, rd_valid_o, state_o, level_o, overflow_o, done_o
  );

  modport slave (
    input  cap_addr_i, cap_data_i, cap_valid_i, arm_i, abort_i,
           trig_addr_i, trig_mask_i, post_count_i, rd_ready_i,
    output rd_addr_o, rd_data_o, rd_valid_o, state_o, level_o, overflow_o, done_o
  );
endinterface

// File: rtl/cart_capture_ctrl.sv
// Trigger/sequencing controller: waits for a masked address match, then stores the
// trigger record plus a programmed window of following records in a FWFT FIFO.
module cart_capture_ctrl #(
  parameter int DEPTH_LOG2 = 6,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           reset_n,
  cart_capture_ctrl_if.slave bus
);
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRIG, S_DONE} state_t;

  state_t           state_q, state_n;
  logic [31:0]      trig_q, mask_q;
  logic [CNT_W-1:0] post_q, cnt_q, cnt_n;
  rec_t             mem [DEPTH];
  rec_t             head_q, wrec;
  logic [PW-1:0]    wptr_q, rptr_q, wptr_n, rptr_n, level, level_n;
  logic             ovf_q, ovf_n, done_q;
  logic             do_arm, do_abort, full, empty, rd_hs, hit, wr_req, wr_en;

  assign do_abort = bus.abort_i;
  assign do_arm   = bus.arm_i & ~bus.abort_i;
  assign level    = wptr_q - rptr_q;
  assign full     = (level == PW'(DEPTH));
  assign empty    = (level == '0);
  // A handshake in the arm cycle is discarded along with the flush.
  assign rd_hs    = ~empty & bus.rd_ready_i & ~do_arm;
  assign hit      = ((bus.cap_addr_i ^ trig_q) & mask_q) == '0;
  assign wrec     = '{addr: bus.cap_addr_i, data: bus.cap_data_i};

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    wr_req  = 1'b0;
    if (do_abort) begin
      state_n = S_IDLE;
    end else if (do_arm) begin
      state_n = S_ARMED;
    end else if (bus.cap_valid_i) begin
      case (state_q)
        S_ARMED: if (hit) begin
          wr_req  = 1'b1;
          cnt_n   = post_q;
          state_n = (post_q == '0) ? S_DONE : S_TRIG;
        end
        S_TRIG: begin
          // Window counts bus events, so drops still decrement.
          wr_req = 1'b1;
          cnt_n  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_n = S_DONE;
        end
        default: ;
      endcase
    end
    wr_en = wr_req & (~full | rd_hs);
    ovf_n = do_arm ? 1'b0 : (ovf_q | (wr_req & ~wr_en));
    if (do_arm) begin
      wptr_n = '0;
      rptr_n = '0;
    end else begin
      wptr_n = wptr_q + PW'(wr_en);
      rptr_n = rptr_q + PW'(rd_hs);
    end
    level_n = wptr_n - rptr_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      trig_q  <= '0;
      mask_q  <= '0;
      post_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      head_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      wptr_q  <= wptr_n;
      rptr_q  <= rptr_n;
      ovf_q   <= ovf_n;
      done_q  <= (state_n == S_DONE);
      if (do_arm) begin
        trig_q <= bus.trig_addr_i;
        mask_q <= bus.trig_mask_i;
        post_q <= bus.post_count_i;
      end
      // Head register: bypass the incoming record when it becomes the new head.
      if (level_n != '0)
        head_q <= (wr_en && rptr_n == wptr_q) ? wrec : mem[rptr_n[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[DEPTH_LOG2-1:0]] <= wrec;
  end

  assign bus.rd_addr_o  = head_q.addr;
  assign bus.rd_data_o  = head_q.data;
  assign bus.rd_valid_o = ~empty;
  assign bus.state_o    = state_q;
  assign bus.level_o    = level;
  assign bus.overflow_o = ovf_q;
  assign bus.done_o     = done_q;
endmodule

// File: tb/tb_cart_capture_ctrl.sv
// Bench for cart_capture_ctrl: directed scenarios plus a random phase, every cycle
// compared against a queue-based behavioural model.
module tb_cart_capture_ctrl;
  localparam int DEPTH_LOG2 = 6;
  localparam int CNT_W      = 16;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cart_capture_ctrl_if #(.DEPTH_LOG2(DEPTH_LOG2), .CNT_W(CNT_W)) bus ();

  cart_capture_ctrl #(.DEPTH_LOG2(DEPTH_LOG2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: record queue, mode 0 idle/1 armed/2 window open/3 done.
  logic [63:0] q[$];
  int          m_state;
  logic        m_ovf;
  logic [31:0] m_trig, m_mask;
  int          m_post, m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_trig  = '0;
    m_mask  = '0;
    m_post  = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    bit hs, wr, acc;
    hs = (q.size() > 0) && bus.rd_ready_i && (!bus.arm_i || bus.abort_i);
    wr = 1'b0;
    if (bus.abort_i) begin
      m_state = 0;
    end else if (bus.arm_i) begin
      q.delete();
      m_ovf   = 1'b0;
      m_trig  = bus.trig_addr_i;
      m_mask  = bus.trig_mask_i;
      m_post  = int'(bus.post_count_i);
      m_state = 1;
      hs      = 1'b0;
    end else if (bus.cap_valid_i) begin
      if (m_state == 1 && ((bus.cap_addr_i & m_mask) == (m_trig & m_mask))) begin
        wr      = 1'b1;
        m_cnt   = m_post;
        m_state = (m_post == 0) ? 3 : 2;
      end else if (m_state == 2) begin
        wr    = 1'b1;
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_state = 3;
      end
    end
    acc = wr && (q.size() < DEPTH || hs);
    if (hs) void'(q.pop_front());
    if (acc) q.push_back({bus.cap_addr_i, bus.cap_data_i});
    else if (wr) m_ovf = 1'b1;
  endtask

  task automatic check_all();
    chk("state", 64'(bus.state_o), 64'(m_state));
    chk("level", 64'(bus.level_o), 64'(q.size()));
    chk("rd_valid", 64'(bus.rd_valid_o), 64'(q.size() > 0));
    chk("overflow", 64'(bus.overflow_o), 64'(m_ovf));
    chk("done", 64'(bus.done_o), 64'(m_state == 3));
    if (q.size() > 0) chk("head", {bus.rd_addr_o, bus.rd_data_o}, q[0]);
  endtask

  // One clock: model consumes the inputs, DUT is sampled 1ns after the edge,
  // then one-cycle pulses are cleared.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    bus.arm_i       = 1'b0;
    bus.abort_i     = 1'b0;
    bus.cap_valid_i = 1'b0;
  endtask

  task automatic do_arm(input logic [31:0] ta, input logic [31:0] tm, input int post);
    bus.trig_addr_i  = ta;
    bus.trig_mask_i  = tm;
    bus.post_count_i = CNT_W'(post);
    bus.arm_i        = 1'b1;
    tick();
    bus.trig_addr_i  = 32'hFFFF_FFFF;
    bus.trig_mask_i  = 32'h0;
    bus.post_count_i = '0;
  endtask

  task automatic cap(input logic [31:0] a, input logic [31:0] d);
    bus.cap_addr_i  = a;
    bus.cap_data_i  = d;
    bus.cap_valid_i = 1'b1;
    tick();
  endtask

  initial begin
    bus.cap_addr_i   = '0;
    bus.cap_data_i   = '0;
    bus.cap_valid_i  = 1'b0;
    bus.arm_i        = 1'b0;
    bus.abort_i      = 1'b0;
    bus.trig_addr_i  = '0;
    bus.trig_mask_i  = '0;
    bus.post_count_i = '0;
    bus.rd_ready_i   = 1'b0;
    model_reset();
    #3;
    check_all();
    chk("rst_addr", 64'(bus.rd_addr_o), 64'h0);
    #9 reset_n = 1'b1;
    tick();

    // Exact-match trigger with a two-record window.
    do_arm(32'h1000_0040, 32'hFFFF_FFFF, 2);
    cap(32'h1000_0000, 32'hA0);
    cap(32'h1000_0040, 32'hA1);
    cap(32'h1000_0044, 32'hA2);
    cap(32'h1000_0048, 32'hA3);
    chk("t1_done_state", 64'(bus.state_o), 64'd3);
    cap(32'h1000_004C, 32'hA4);
    chk("t1_level", 64'(bus.level_o), 64'd3);
    chk("t1_head", 64'(bus.rd_addr_o), 64'h1000_0040);
    bus.rd_ready_i = 1'b1;
    repeat (4) tick();

    // Mask 0 / post 0: first record triggers and finishes.
    do_arm(32'h0, 32'h0, 0);
    bus.rd_ready_i = 1'b0;
    cap(32'h1000_0000, 32'hDEAD_BEEF);
    chk("t2_valid", 64'(bus.rd_valid_o), 64'd1);
    chk("t2_data", {bus.rd_addr_o, bus.rd_data_o}, 64'h1000_0000_DEAD_BEEF);
    chk("t2_done", 64'(bus.done_o), 64'd1);

    // Overflow: 71-event window into a 64-deep FIFO with no reads.
    do_arm(32'h0, 32'h0, 70);
    for (int i = 0; i < 75; i++) cap(32'(i), $urandom);
    chk("t3_level", 64'(bus.level_o), 64'(DEPTH));
    chk("t3_ovf", 64'(bus.overflow_o), 64'd1);
    bus.rd_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_order", 64'(bus.rd_addr_o), 64'(i));
      tick();
    end

    // Full FIFO with continuous read and back-to-back writes.
    bus.rd_ready_i = 1'b0;
    do_arm(32'h0, 32'h0, 200);
    chk("t4_ovf_cleared", 64'(bus.overflow_o), 64'd0);
    for (int i = 0; i < DEPTH; i++) cap(32'h2000_0000 + 32'(i), $urandom);
    bus.rd_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) cap(32'h3000_0000 + 32'(i), $urandom);
    chk("t4_level", 64'(bus.level_o), 64'(DEPTH));
    chk("t4_ovf", 64'(bus.overflow_o), 64'd0);
    repeat (DEPTH + 2) tick();

    // arm+abort together while the window is open: abort wins.
    bus.rd_ready_i = 1'b0;
    do_arm(32'h0, 32'h0, 10);
    repeat (3) cap($urandom, $urandom);
    bus.arm_i   = 1'b1;
    bus.abort_i = 1'b1;
    tick();
    chk("t5_state", 64'(bus.state_o), 64'd0);
    chk("t5_level", 64'(bus.level_o), 64'd3);
    do_arm(32'h0, 32'h0, 1);
    chk("t5_flush", 64'(bus.level_o), 64'd0);

    // Random phase.
    do_arm(32'h100, 32'hFFFF_FFF0, 20);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] masks [3];
      masks[0] = 32'h0; masks[1] = 32'hFFFF_FFFF; masks[2] = 32'hFFFF_FFF0;
      bus.rd_ready_i = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 39) == 0) begin
        bus.trig_addr_i  = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h104;
        bus.trig_mask_i  = masks[$urandom_range(0, 2)];
        bus.post_count_i = CNT_W'($urandom_range(0, 80));
        bus.arm_i        = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) bus.abort_i = 1'b1;
      bus.cap_valid_i = ($urandom_range(0, 9) < 7);
      bus.cap_addr_i  = 32'h100 + 32'(4 * $urandom_range(0, 7));
      bus.cap_data_i  = $urandom;
      tick();
    end

    // Asynchronous reset between edges while the window is open.
    bus.rd_ready_i = 1'b0;
    do_arm(32'h0, 32'h0, 50);
    repeat (5) cap($urandom, $urandom);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("ar_addr", 64'(bus.rd_addr_o), 64'h0);
    chk("ar_data", 64'(bus.rd_data_o), 64'h0);
    #3 reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
